// File: rtl/instr_decoder_pkg.sv
// Shared opcode constants, register-file types and decoder state for the decode stage.
package instr_decoder_pkg;

    localparam logic [4:0] SelsOpCode = 5'd7;
    localparam logic [4:0] HaltOpCode = 5'd31;
    localparam logic [4:0] NopOpCode  = 5'd0;

    // Register-file operation codes; the encoding is the raw opcode field.
    typedef enum logic [4:0] {
        OpNop  = 5'd0,
        OpAdd  = 5'd4,
        OpSub  = 5'd5,
        OpMov  = 5'd6,
        OpLoad = 5'd8,
        OpStor = 5'd9,
        OpIncr = 5'd10,
        OpDecr = 5'd11,
        OpAnd  = 5'd12,
        OpOr   = 5'd13,
        OpBizr = 5'd14,
        OpBnzr = 5'd15,
        OpXor  = 5'd16,
        OpNot  = 5'd17,
        OpShl  = 5'd18,
        OpShr  = 5'd19,
        OpRol  = 5'd20,
        OpRor  = 5'd21,
        OpCmp  = 5'd22,
        OpJmp  = 5'd23,
        OpCall = 5'd24,
        OpRet  = 5'd25,
        OpPush = 5'd26,
        OpPop  = 5'd27
    } reg_OP;

    typedef logic [3:0] register;

    typedef enum logic [1:0] {
        DecRst,
        DecRun,
        DecHalt
    } dec_state;

    // Opcodes that do nothing and are not counted as retired.
    function automatic logic is_nop_op(input logic [4:0] op);
        return (op < 5'd4) || ((op >= 5'd28) && (op <= 5'd30));
    endfunction

endpackage

// File: rtl/instr_decoder_op_classifier.sv
// Combinational opcode classifier: register-file op code and operand routing class.
module op_classifier
    import instr_decoder_pkg::*;
#(
    parameter logic [4:0] SelsOp = SelsOpCode,
    parameter logic [4:0] HaltOp = HaltOpCode
) (
    input  logic [4:0] op_i,
    output logic [4:0] reg_op_o,
    output logic       src_from_opnd_o,
    output logic       dst_from_opnd_o,
    output logic       src_zero_o,
    output logic       is_sels_o,
    output logic       is_halt_o
);

    // Map opcode to register-file op and source/destination routing.
    always_comb begin
        reg_op_o        = NopOpCode;
        src_from_opnd_o = 1'b0;
        dst_from_opnd_o = 1'b0;
        src_zero_o      = 1'b0;
        is_sels_o       = (op_i == SelsOp);
        is_halt_o       = (op_i == HaltOp);

        if (!is_nop_op(op_i) && !is_sels_o && !is_halt_o) begin
            reg_op_o = op_i;
        end

        case (op_i)
            OpMov: dst_from_opnd_o = 1'b1;
            OpLoad: begin
                dst_from_opnd_o = 1'b1;
                src_zero_o      = 1'b1;
            end
            OpStor, OpBizr, OpBnzr: src_from_opnd_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// Decode stage feeding the register file: run/halt FSM, SELS source latch, retire counter.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter logic [4:0]  SELS_OP = SelsOpCode,
    parameter logic [4:0]  HALT_OP = HaltOpCode
) (
    input  logic             clk,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic [9:0]       p,
    output logic [4:0]       reg_op,
    output logic [3:0]       reg_src,
    output logic [3:0]       reg_dst,
    output logic [3:0]       instr_o,
    output logic             movp,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic [9:0]       halt_pc
);

    logic [4:0]       op;
    logic [3:0]       opnd;
    logic             active;

    dec_state         state_q;
    logic             done_q;
    logic [9:0]       halt_pc_q;
    register          sel_src_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]       cls_reg_op;
    logic             cls_src_from_opnd;
    logic             cls_dst_from_opnd;
    logic             cls_src_zero;
    logic             cls_is_sels;
    logic             cls_is_halt;

    assign op      = instr[8:4];
    assign opnd    = instr[3:0];
    assign instr_o = opnd;

    // RST counts as active so the word at p=0 executes in the first non-start cycle.
    assign active = !start && (state_q != DecHalt);

    op_classifier #(
        .SelsOp(SELS_OP),
        .HaltOp(HALT_OP)
    ) u_op_classifier (
        .op_i           (op),
        .reg_op_o       (cls_reg_op),
        .src_from_opnd_o(cls_src_from_opnd),
        .dst_from_opnd_o(cls_dst_from_opnd),
        .src_zero_o     (cls_src_zero),
        .is_sels_o      (cls_is_sels),
        .is_halt_o      (cls_is_halt)
    );

    // Combinational decode outputs; forced to NOP with zero selects when not active.
    always_comb begin
        reg_op  = NopOpCode;
        reg_src = '0;
        reg_dst = '0;
        movp    = 1'b0;
        if (active) begin
            reg_op = cls_reg_op;
            if (cls_src_zero) begin
                reg_src = '0;
            end else if (cls_src_from_opnd) begin
                reg_src = opnd;
            end else begin
                reg_src = sel_src_q;
            end
            reg_dst = cls_dst_from_opnd ? opnd : 4'h0;
            movp    = (op == OpMov) && (opnd == 4'hF);
        end
    end

    // Run/halt FSM with registered done flag and halt-PC capture.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q   <= DecRst;
            done_q    <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            unique case (state_q)
                DecRst, DecRun: begin
                    if (cls_is_halt) begin
                        state_q   <= DecHalt;
                        done_q    <= 1'b1;
                        halt_pc_q <= p;
                    end else begin
                        state_q <= DecRun;
                    end
                end
                DecHalt: state_q <= DecHalt;
                default: state_q <= DecRst;
            endcase
        end
    end

    // Source-select latch: a SELS takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            sel_src_q <= '0;
        end else if (active && cls_is_sels) begin
            sel_src_q <= opnd;
        end
    end

    // Retired-instruction count, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (active && !is_nop_op(op) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (start) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done        = done_q;
    assign halt_pc     = halt_pc_q;
    assign instr_count = cnt_q;

endmodule
